// File: rtl/mem_rw_be.sv
// mem_rw_be: byte-addressed data memory model with per-byte enables and an
// address-dependent access delay, driven through a single-request
// start/ready/done handshake.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset; clears the whole array
//   start_i    request strobe, sampled only while ready_o is high
//   we_i       1 = write, 0 = read; latched with start_i
//   address_i  byte address of lane 0 (wraps modulo SIZE)
//   byte_en_i  per-lane enable, used by both reads and writes
//   data_in_i  write data, lane k = bits [8k+7:8k]
//   ready_o    idle and able to accept a request
//   done_o     one-cycle completion pulse
//   data_out_o read result, held until the next read completes
//
// Behavioural model for simulation and FPGA bring-up only.

module mem_rw_be #(
   parameter int unsigned SIZE          = 256,
   parameter int unsigned ADDRESS_WIDTH = 8,
   parameter int unsigned DATA_BYTES    = 4,
   parameter int unsigned BASE_DELAY    = 0,
   parameter int unsigned DELAY_BITS    = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start_i,
   input  logic                       we_i,
   input  logic [ADDRESS_WIDTH-1:0]   address_i,
   input  logic [DATA_BYTES-1:0]      byte_en_i,
   input  logic [8*DATA_BYTES-1:0]    data_in_i,
   output logic                       ready_o,
   output logic                       done_o,
   output logic [8*DATA_BYTES-1:0]    data_out_o
);

   localparam int unsigned DataW = 8 * DATA_BYTES;
   localparam int unsigned IdxW  = (SIZE > 1) ? $clog2(SIZE) : 1;

   // Delay = BASE_DELAY + low DELAY_BITS of the address; the mask is all-zero
   // when DELAY_BITS is 0, which removes the variable part.
   localparam logic [7:0] DelayBase = 8'(BASE_DELAY);
   localparam logic [7:0] DelayMask = 8'((1 << DELAY_BITS) - 1);

   typedef enum logic [0:0] {
      StIdle,
      StWait
   } state_e;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_e state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic done_q, done_d;

   // Latched request
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic                     we_q;
   logic [DATA_BYTES-1:0]    be_q;
   logic [DataW-1:0]         wdata_q;

   logic [DataW-1:0] data_out_q;
   logic [7:0]       mem_q [SIZE];

   // Control strobes from the FSM
   logic req_load;
   logic access;

   // Per-lane array index and gathered read data
   logic [IdxW-1:0]  lane_idx [DATA_BYTES];
   logic [DataW-1:0] rdata;

   // ------------------------------------------------------------------
   // FSM next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      req_load = 1'b0;
      access   = 1'b0;

      case (state_q)
         StIdle: begin
            if (start_i) begin
               req_load = 1'b1;
               cnt_d    = DelayBase + (8'(address_i) & DelayMask);
               state_d  = StWait;
            end
         end
         StWait: begin
            // Inputs are ignored here; a start while busy is simply dropped.
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               access  = 1'b1;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= 8'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // ------------------------------------------------------------------
   // Request latch
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
      end else if (req_load) begin
         addr_q  <= address_i;
         we_q    <= we_i;
         be_q    <= byte_en_i;
         wdata_q <= data_in_i;
      end
   end

   // ------------------------------------------------------------------
   // Lane addressing: addr+k is formed wide enough that the carry out of
   // ADDRESS_WIDTH is kept, then reduced modulo SIZE (SIZE need not be a
   // power of two, so plain truncation would be wrong).
   // ------------------------------------------------------------------
   always_comb begin
      for (int k = 0; k < DATA_BYTES; k++) begin
         lane_idx[k] = IdxW'((32'(addr_q) + 32'(k)) % SIZE);
      end
   end

   // Disabled lanes read back as zero.
   always_comb begin
      rdata = '0;
      for (int k = 0; k < DATA_BYTES; k++) begin
         if (be_q[k]) begin
            rdata[8*k +: 8] = mem_q[lane_idx[k]];
         end
      end
   end

   // ------------------------------------------------------------------
   // Storage array. Reset clears every byte; an aborted request never
   // reaches the access cycle, so it writes nothing.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SIZE; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else if (access && we_q) begin
         for (int k = 0; k < DATA_BYTES; k++) begin
            if (be_q[k]) begin
               mem_q[lane_idx[k]] <= wdata_q[8*k +: 8];
            end
         end
      end
   end

   // Read result register; writes leave it untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_out_q <= '0;
      end else if (access && !we_q) begin
         data_out_q <= rdata;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign ready_o    = (state_q == StIdle);
   assign done_o     = done_q;
   assign data_out_o = data_out_q;

endmodule
